accel_multi_filter: RTL and testbench
=====================================

# accel_multi_filter

Parametrised multi-channel accelerometer sample conditioner. It sits between `spi_control` and the calculator/display logic and replaces the single-axis smoothing path. Each `data_update` strobe delivers a packed vector of axis samples. The block runs them through a per-channel moving-average filter with a power-of-two depth, subtracts a user-captured zero offset with saturation, and, optionally, derives hysteretic tilt flags. Channels are processed one per cycle by a single shared datapath.

## Interface
- `NUM_CH`, 2: number of axes, 1..4.
- `DATA_W`, 16: sample width, two's complement.
- `LOG2_DEPTH`, 3: moving-average depth is 2^LOG2_DEPTH, range 0..5.
- `TILT_HI`, 64: tilt set threshold (signed, >0).
- `TILT_LO`, 32: tilt clear threshold (signed, 0 ≤ TILT_LO < TILT_HI).

- `clk`  in  1  system clock; the same domain as `spi_control` `data_update`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  one-cycle strobe indicating that `sample_data` is valid.
- `sample_data`  in  NUM_CH*DATA_W  packed samples; channel 0 occupies the LSBs.
- `cal_req`  in  1  pulse: capture current filtered values as offsets.
- `cal_clr`  in  1  pulse: zero all offsets.
- `out_valid`  out  1  one-cycle pulse marking the cycle in which a new `out_data` is visible.
- `out_data`  out  NUM_CH*DATA_W  filtered value minus offset, saturated, packed like the input.
- `busy`  out  1  high while a sample is in flight.
- `overrun`  out  1  sticky; set when a strobe is dropped; cleared only by reset.
- `tilt_pos`  out  NUM_CH  per-channel positive-tilt flag.
- `tilt_neg`  out  NUM_CH  per-channel negative-tilt flag.

## Operation
**FSM states:** IDLE, ACCUM, EMIT.
- **IDLE:** on `sample_valid`, latch `sample_data`, set channel index to 0, and go to ACCUM.
- **ACCUM:** one cycle per channel `c`.
  - `sum[c] <= sum[c] + new[c] - ring[c][wr_ptr]`, then `ring[c][wr_ptr] <= new[c]`.
  - `filt[c] = sum_new >>> LOG2_DEPTH` (arithmetic shift). `filt[c]` is stored in a shadow register.
  - After channel NUM_CH-1, `wr_ptr` increments modulo 2^LOG2_DEPTH and the FSM goes to EMIT.
- **EMIT:** commit `out_data[c] = sat(filt[c] - offset[c])` for all channels simultaneously, update tilt flags, pulse `out_valid`, then return to IDLE.

**Arithmetic:**
- `sum` width is DATA_W+LOG2_DEPTH, signed, and never overflows.
- The subtraction is computed in DATA_W+1 bits and clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].

**Warm-up:** ring buffers and sums reset to 0, so the first 2^LOG2_DEPTH-1 outputs ramp toward the input. This is intended behaviour.

**Calibration:**
- `cal_req` copies the latest committed `filt[c]` (the pre-offset value) into `offset[c]` for every channel. If no sample has been emitted yet, the captured value is 0.
- If `cal_req` coincides with EMIT, the `filt` values being committed in that cycle are captured.
- The new offset applies from the next EMIT onward; `out_data` is not rewritten retroactively.
- `cal_clr` zeros the offsets. If `cal_req` and `cal_clr` arrive together, `cal_clr` wins.
- Both calibration inputs are accepted in any FSM state.

**Dropped samples:** a `sample_valid` arriving in ACCUM or EMIT is dropped, and `overrun` goes high on the next cycle.

## Timing
- **Latency:** a strobe accepted in cycle T produces `out_valid` high in cycle T+NUM_CH+1, with `out_data` valid in that same cycle. `out_data` then holds until the next EMIT.
- **`busy`:** high for cycles T+1 .. T+NUM_CH+1 inclusive.
- **Throughput:** one accepted sample per NUM_CH+2 cycles. A strobe at T+NUM_CH+2 is accepted.
- **Reset values:** `out_valid`, `out_data`, `busy`, `overrun`, `tilt_pos` and `tilt_neg` are all 0. FSM returns to IDLE; `wr_ptr`, sums, ring buffers and offsets are all 0.
- **Reset mid-operation:** aborts immediately; no `out_valid` is generated for the in-flight sample.
- **Simultaneous strobe and `out_valid`:** a strobe in the EMIT cycle is dropped.

## Configuration
- **Macro:** `ACCEL_FILT_TILT_EN`.
- **Defined:** tilt flags update only in EMIT, based on the newly committed `out_data[c]`.
  - `tilt_pos` sets when out > TILT_HI and clears when out < TILT_LO; otherwise it holds.
  - `tilt_neg` sets when out < -TILT_HI and clears when out > -TILT_LO; otherwise it holds.
  - The two flags are never both 1.
- **Undefined:** no tilt logic is built; `tilt_pos` and `tilt_neg` are tied to 0. The TILT_* parameters are ignored.

## Structure
- **Package `accel_filt_pkg`:**
  - FSM state enum.
  - `SUM_W = DATA_W+LOG2_DEPTH` width helper.
  - Signed saturating-subtract function.
- **Sub-module `accel_chan_ram`:** ring storage with NUM_CH*2^LOG2_DEPTH words of DATA_W bits, addressed by {channel, wr_ptr}. It has a combinational read and a synchronous write, and is cleared on reset.

## Test plan
Bench configuration unless stated: NUM_CH=2, DATA_W=16, LOG2_DEPTH=2, macro defined.
- **Ramp:** after reset, four strobes with ch0=100, ch1=-100, spaced 6 cycles apart → `out_data` ch0 reads 25, 50, 75, 100 and ch1 reads -25, -50, -75, -100. Each `out_valid` arrives 3 cycles after its strobe.
- **Overrun:** strobes at T and T+2 → a single `out_valid` at T+3; `overrun`=1 from T+3 and stays 1.
- **Calibration:** with steady input 100, pulse `cal_req` → the following outputs read 0. Then pulse `cal_clr` → outputs read 100. With `cal_req` and `cal_clr` pulsed together, offsets read 0.
- **Saturation:** with steady 32767, pulse `cal_req`, then apply four strobes of -32768 → ch0 `out_data` = -32768, not a wrapped value.
- **Tilt hysteresis:**
  - Steady 80 → `tilt_pos`=1.
  - Steady 50 → `tilt_pos` stays 1.
  - Steady 20 → `tilt_pos`=0.
  - Steady -80 → `tilt_neg`=1.
  - Rebuilt with the macro undefined: both flags stay 0 throughout.
- **Reset mid-operation:** drive `reset_n` low at T+1 after a strobe → no `out_valid`; all outputs 0. The next strobe after release behaves as the first post-reset sample (25 for an input of 100).

Source files
------------

// File: rtl/accel_filt_pkg.sv
// Shared FSM type, width helper and saturating subtract for accel_multi_filter.
package accel_filt_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  localparam int MAX_W = 32;

  function automatic int sum_w(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

  // Operands already fit in w bits (w <= 31), so the raw difference cannot wrap in MAX_W.
  function automatic logic signed [MAX_W-1:0] sat_sub(input logic signed [MAX_W-1:0] a,
                                                       input logic signed [MAX_W-1:0] b,
                                                       input int w);
    logic signed [MAX_W-1:0] d;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    d  = a - b;
    hi = $signed((32'd1 << (w - 1)) - 32'd1);
    lo = -hi - 32'sd1;
    if (d > hi) return hi;
    else if (d < lo) return lo;
    else return d;
  endfunction

endpackage

// File: rtl/accel_chan_ram.sv
// Per-channel ring storage for the moving average: combinational read, synchronous write.
module accel_chan_ram #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 16,
  parameter int LOG2_DEPTH = 3,
  parameter int CH_W       = 1,
  parameter int PTR_W      = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [CH_W-1:0]          ch,
  input  logic [PTR_W-1:0]         ptr,
  input  logic                     we,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic signed [DATA_W-1:0] rd_data
);
  localparam int WORDS = NUM_CH * (1 << LOG2_DEPTH);
  localparam int AW    = CH_W + LOG2_DEPTH;

  logic [AW-1:0]            addr;
  logic signed [DATA_W-1:0] mem_q [WORDS];
  logic signed [DATA_W-1:0] mem_d [WORDS];

  if (LOG2_DEPTH == 0) begin : g_addr_ch
    assign addr = ch;
  end else begin : g_addr_ptr
    assign addr = {ch, ptr[LOG2_DEPTH-1:0]};
  end

  assign rd_data = mem_q[addr];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[addr] = wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/accel_multi_filter.sv
// Multi-channel moving-average filter with saturating zero-offset removal.
// Optional hysteretic tilt flags are built when ACCEL_FILT_TILT_EN is defined.
module accel_multi_filter
  import accel_filt_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 16,
  parameter int LOG2_DEPTH = 3,
  parameter int TILT_HI    = 64,
  parameter int TILT_LO    = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] sample_data,
  input  logic                     cal_req,
  input  logic                     cal_clr,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     busy,
  output logic                     overrun,
  output logic [NUM_CH-1:0]        tilt_pos,
  output logic [NUM_CH-1:0]        tilt_neg
);
  localparam int SUM_W = sum_w(DATA_W, LOG2_DEPTH);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  if (NUM_CH < 1 || NUM_CH > 4 || DATA_W > 31 || LOG2_DEPTH < 0 || LOG2_DEPTH > 5 ||
      TILT_LO < 0 || TILT_LO >= TILT_HI) begin : g_bad_params
    $error("accel_multi_filter: illegal parameter set");
  end

  state_t                   state_q, state_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [NUM_CH*DATA_W-1:0] samp_q, samp_d;
  logic signed [SUM_W-1:0]  sum_q [NUM_CH];
  logic signed [SUM_W-1:0]  sum_d [NUM_CH];
  logic signed [DATA_W-1:0] filt_q [NUM_CH];
  logic signed [DATA_W-1:0] filt_d [NUM_CH];
  logic signed [DATA_W-1:0] cfilt_q [NUM_CH];
  logic signed [DATA_W-1:0] cfilt_d [NUM_CH];
  logic signed [DATA_W-1:0] offset_q [NUM_CH];
  logic signed [DATA_W-1:0] offset_d [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;

  logic signed [DATA_W-1:0] new_s, ram_rd, filt_new;
  logic signed [SUM_W-1:0]  sum_new;
  logic signed [DATA_W-1:0] commit_f [NUM_CH];
  logic signed [DATA_W-1:0] commit_o [NUM_CH];
  logic                     ram_we;
  logic                     commit_en;

  accel_chan_ram #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH), .CH_W(CH_W), .PTR_W(PTR_W)
  ) u_ram (
    .clk(clk), .reset_n(reset_n), .ch(ch_q), .ptr(wr_ptr_q),
    .we(ram_we), .wr_data(new_s), .rd_data(ram_rd)
  );

  // Shared datapath for the channel selected by ch_q; results commit on the last channel
  // so out_data is already visible in the EMIT cycle.
  always_comb begin
    new_s     = samp_q[int'(ch_q)*DATA_W +: DATA_W];
    sum_new   = sum_q[ch_q] + SUM_W'(new_s) - SUM_W'(ram_rd);
    filt_new  = DATA_W'(sum_new >>> LOG2_DEPTH);
    commit_en = (state_q == ACCUM) && (ch_q == LAST_CH);
    for (int c = 0; c < NUM_CH; c++) begin
      commit_f[c] = (c == NUM_CH - 1) ? filt_new : filt_q[c];
      commit_o[c] = DATA_W'(sat_sub(MAX_W'(commit_f[c]), MAX_W'(offset_q[c]), DATA_W));
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    wr_ptr_d    = wr_ptr_q;
    samp_d      = samp_q;
    sum_d       = sum_q;
    filt_d      = filt_q;
    cfilt_d     = cfilt_q;
    offset_d    = offset_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    ram_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          samp_d  = sample_data;
          ch_d    = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (sample_valid) overrun_d = 1'b1;
        ram_we        = 1'b1;
        sum_d[ch_q]   = sum_new;
        filt_d[ch_q]  = filt_new;
        if (commit_en) begin
          ch_d        = '0;
          wr_ptr_d    = (LOG2_DEPTH == 0) ? '0 : wr_ptr_q + 1'b1;
          state_d     = EMIT;
          out_valid_d = 1'b1;
          for (int c = 0; c < NUM_CH; c++) begin
            cfilt_d[c] = commit_f[c];
            out_data_d[c*DATA_W +: DATA_W] = commit_o[c];
          end
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      EMIT: begin
        if (sample_valid) overrun_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // cfilt_q already holds the values committed for this EMIT, if any.
    if (cal_clr) begin
      for (int c = 0; c < NUM_CH; c++) offset_d[c] = '0;
    end else if (cal_req) begin
      offset_d = cfilt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      wr_ptr_q    <= '0;
      samp_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum_q[c]    <= '0;
        filt_q[c]   <= '0;
        cfilt_q[c]  <= '0;
        offset_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      wr_ptr_q    <= wr_ptr_d;
      samp_q      <= samp_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      sum_q       <= sum_d;
      filt_q      <= filt_d;
      cfilt_q     <= cfilt_d;
      offset_q    <= offset_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

`ifdef ACCEL_FILT_TILT_EN
  logic [NUM_CH-1:0] tilt_pos_q, tilt_pos_d;
  logic [NUM_CH-1:0] tilt_neg_q, tilt_neg_d;

  // Set and clear thresholds are disjoint, so pos and neg can never both be set.
  always_comb begin
    tilt_pos_d = tilt_pos_q;
    tilt_neg_d = tilt_neg_q;
    if (commit_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (commit_o[c] > TILT_HI) tilt_pos_d[c] = 1'b1;
        else if (commit_o[c] < TILT_LO) tilt_pos_d[c] = 1'b0;
        if (commit_o[c] < -TILT_HI) tilt_neg_d[c] = 1'b1;
        else if (commit_o[c] > -TILT_LO) tilt_neg_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tilt_pos_q <= '0;
      tilt_neg_q <= '0;
    end else begin
      tilt_pos_q <= tilt_pos_d;
      tilt_neg_q <= tilt_neg_d;
    end
  end

  assign tilt_pos = tilt_pos_q;
  assign tilt_neg = tilt_neg_q;
`else
  assign tilt_pos = '0;
  assign tilt_neg = '0;
`endif
endmodule

// File: tb/tb_accel_multi_filter.sv
// Directed scoreboard bench for accel_multi_filter (NUM_CH=2, DATA_W=16, LOG2_DEPTH=2).
module tb_accel_multi_filter;
  localparam int NUM_CH     = 2;
  localparam int DATA_W     = 16;
  localparam int LOG2_DEPTH = 2;
  localparam int TILT_HI    = 64;
  localparam int TILT_LO    = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [31:0] sample_data = '0;
  logic        cal_req = 1'b0;
  logic        cal_clr = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        busy;
  logic        overrun;
  logic [1:0]  tilt_pos;
  logic [1:0]  tilt_neg;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         o0;
    int         o1;
    logic [1:0] tp;
    logic [1:0] tn;
  } exp_t;

  exp_t expq[$];

  int         hist [2][4];
  int         hp;
  int         mf [2];
  int         moff [2];
  logic [1:0] mtp;
  logic [1:0] mtn;

  accel_multi_filter #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH),
    .TILT_HI(TILT_HI), .TILT_LO(TILT_LO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .cal_req(cal_req), .cal_clr(cal_clr), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .overrun(overrun), .tilt_pos(tilt_pos), .tilt_neg(tilt_neg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) hist[c][k] = 0;
      mf[c] = 0;
      moff[c] = 0;
    end
    hp  = 0;
    mtp = '0;
    mtn = '0;
  endtask

  task automatic model_push(input int a, input int b);
    exp_t e;
    int   s;
    int   o [2];
    hist[0][hp] = a;
    hist[1][hp] = b;
    hp = (hp + 1) % 4;
    for (int c = 0; c < 2; c++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += hist[c][k];
      mf[c] = s >>> 2;
      o[c]  = clamp16(mf[c] - moff[c]);
`ifdef ACCEL_FILT_TILT_EN
      if (o[c] > TILT_HI) mtp[c] = 1'b1;
      else if (o[c] < TILT_LO) mtp[c] = 1'b0;
      if (o[c] < -TILT_HI) mtn[c] = 1'b1;
      else if (o[c] > -TILT_LO) mtn[c] = 1'b0;
`endif
    end
    e.o0 = o[0];
    e.o1 = o[1];
    e.tp = mtp;
    e.tn = mtn;
    expq.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (expq.size() == 0) begin
      check({tag, ".queue"}, 0, 1);
    end else begin
      e = expq.pop_front();
      check({tag, ".ch0"}, $signed(out_data[15:0]), e.o0);
      check({tag, ".ch1"}, $signed(out_data[31:16]), e.o1);
      check({tag, ".tpos"}, {30'b0, tilt_pos}, {30'b0, e.tp});
      check({tag, ".tneg"}, {30'b0, tilt_neg}, {30'b0, e.tn});
    end
  endtask

  task automatic send(input string tag, input int a, input int b);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = {b[15:0], a[15:0]};
    model_push(a, b);
    @(negedge clk);
    sample_valid = 1'b0;
    check({tag, ".busy1"}, busy, 1);
    check({tag, ".vld_early"}, out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    check({tag, ".vld"}, out_valid, 1);
    check({tag, ".busy3"}, busy, 1);
    check_out(tag);
    @(negedge clk);
    check({tag, ".vld_after"}, out_valid, 0);
    check({tag, ".busy_after"}, busy, 0);
  endtask

  task automatic cal(input logic req, input logic clr);
    @(negedge clk);
    cal_req = req;
    cal_clr = clr;
    @(negedge clk);
    cal_req = 1'b0;
    cal_clr = 1'b0;
    if (clr) begin
      moff[0] = 0;
      moff[1] = 0;
    end else if (req) begin
      moff[0] = mf[0];
      moff[1] = mf[1];
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst.vld", out_valid, 0);
    check("rst.data", out_data, 0);
    check("rst.busy", busy, 0);
    check("rst.ovr", overrun, 0);
    check("rst.tilt", {tilt_pos, tilt_neg}, 0);

    // Warm-up ramp
    for (int i = 0; i < 4; i++) send("ramp", 100, -100);
    check("ramp.final0", $signed(out_data[15:0]), 100);
    check("ramp.final1", $signed(out_data[31:16]), -100);

    // Calibration
    cal(1'b1, 1'b0);
    send("cal_req", 100, -100);
    check("cal_req.zero", $signed(out_data[15:0]), 0);
    cal(1'b0, 1'b1);
    send("cal_clr", 100, -100);
    cal(1'b1, 1'b0);
    send("cal_req2", 100, -100);
    cal(1'b1, 1'b1);
    send("cal_both", 100, -100);
    check("cal_both.ch0", $signed(out_data[15:0]), 100);

    // Tilt hysteresis
    for (int i = 0; i < 4; i++) send("tilt80", 80, -80);
    for (int i = 0; i < 4; i++) send("tilt50", 50, -50);
    for (int i = 0; i < 4; i++) send("tilt20", 20, -20);
    for (int i = 0; i < 4; i++) send("tiltm80", -80, 80);

    // Saturation
    for (int i = 0; i < 4; i++) send("satmax", 32767, 32767);
    cal(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send("satmin", -32768, -32768);
    check("sat.ch0", $signed(out_data[15:0]), -32768);

    // Overrun: second strobe lands two cycles after the first
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = {16'd200, 16'd200};
    model_push(200, 200);
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    check("ovr.before", overrun, 0);
    sample_valid = 1'b1;
    sample_data  = {16'd999, 16'd999};
    @(negedge clk);
    sample_valid = 1'b0;
    check("ovr.vld", out_valid, 1);
    check("ovr.flag", overrun, 1);
    check_out("ovr");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("ovr.single", out_valid, 0);
    end
    check("ovr.sticky", overrun, 1);

    // Reset in flight
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = {16'd300, 16'd300};
    @(negedge clk);
    sample_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid.data", out_data, 0);
    check("mid.busy", busy, 0);
    check("mid.ovr", overrun, 0);
    check("mid.tilt", {tilt_pos, tilt_neg}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid.vld", out_valid, 0);
    end
    reset_n = 1'b1;
    model_reset();
    send("post_rst", 100, 100);
    check("post_rst.ch0", $signed(out_data[15:0]), 25);
    check("queue.empty", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
